// File: rtl/fmac_pkg.sv
// Shared types and schedule constants for the 4-term floating-point
// dot-product sequencer (FloPoCo 11-bit format: exn[10:9] sign[8] exp[7:4] frac[3:0]).
package fmac_pkg;

    localparam int WE = 4;
    localparam int WF = 4;
    localparam int W  = 2 + 1 + WE + WF;

    typedef logic [W-1:0] float_t;

    // FloPoCo exception field encodings
    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    // Schedule steps (step number == index of the active stateNN input)
    localparam logic [3:0] STEP_IDLE   = 4'd0;
    localparam logic [3:0] ISSUE_FIRST = 4'd1;
    localparam logic [3:0] ISSUE_LAST  = 4'd4;
    localparam logic [3:0] P1_CAPTURE  = 4'd3;
    localparam logic [3:0] ADD_FIRST   = 4'd4;
    localparam logic [3:0] ADD_LAST    = 4'd6;
    localparam logic [3:0] DONE        = 4'd7;

    // Collapse the one-hot schedule to a step number; the lowest-numbered
    // asserted state wins if several are high.
    function automatic logic [3:0] onehot_to_step(input logic [15:1] st);
        logic [3:0] s;
        s = STEP_IDLE;
        for (int i = 15; i >= 1; i--) begin
            if (st[i]) s = 4'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/fmac_operand_mux.sv
// Step-to-operand decode: selects multiplier/adder operands and enables
// for the current schedule step. Purely combinational.
module fmac_operand_mux
    import fmac_pkg::*;
(
    input  logic         reset,
    input  logic [3:0]   step,
    input  logic [W-1:0] arg1,
    input  logic [W-1:0] arg2,
    input  logic [W-1:0] arg3,
    input  logic [W-1:0] arg4,
    input  logic [W-1:0] arg5,
    input  logic [W-1:0] arg6,
    input  logic [W-1:0] arg7,
    input  logic [W-1:0] arg8,
    input  logic [W-1:0] p1,
    input  logic [W-1:0] fmul_r,
    input  logic [W-1:0] fadd_r,
    output logic [W-1:0] fmul_x,
    output logic [W-1:0] fmul_y,
    output logic         fmul_ce,
    output logic [W-1:0] fadd_x,
    output logic [W-1:0] fadd_y,
    output logic         fadd_ce
);

    // Operand/enable decode; everything is forced to zero while reset is low.
    always_comb begin
        fmul_x  = '0;
        fmul_y  = '0;
        fmul_ce = 1'b0;
        fadd_x  = '0;
        fadd_y  = '0;
        fadd_ce = 1'b0;
        if (reset) begin
            case (step)
                4'd1: begin fmul_x = arg1; fmul_y = arg2; end
                4'd2: begin fmul_x = arg3; fmul_y = arg4; end
                4'd3: begin fmul_x = arg5; fmul_y = arg6; end
                4'd4: begin fmul_x = arg7; fmul_y = arg8; end
                default: ;
            endcase
            // One extra enabled edge after the last issue drains P4 out of
            // the two-stage multiplier.
            fmul_ce = (step >= ISSUE_FIRST) && (step <= ISSUE_LAST + 4'd1);
            if (step == ADD_FIRST) begin
                fadd_x  = p1;
                fadd_y  = fmul_r;
                fadd_ce = 1'b1;
            end else if ((step > ADD_FIRST) && (step <= ADD_LAST)) begin
                fadd_x  = fadd_r;
                fadd_y  = fmul_r;
                fadd_ce = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmac_dot4_ctrl.sv
// Sequencer for R = a1*a2 + a3*a4 + a5*a6 + a7*a8 on a shared external
// fmul (latency 2) and fadd (latency 1), stepped by an external one-hot FSM.
// The final sum is left held on fadd_r.
// Optional macro FMAC_RESULT_REG_EN adds a registered result (acc_r/acc_valid).
module fmac_dot4_ctrl
    import fmac_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] arg1,
    input  logic [W-1:0] arg2,
    input  logic [W-1:0] arg3,
    input  logic [W-1:0] arg4,
    input  logic [W-1:0] arg5,
    input  logic [W-1:0] arg6,
    input  logic [W-1:0] arg7,
    input  logic [W-1:0] arg8,
    output logic [W-1:0] fmul_x,
    output logic [W-1:0] fmul_y,
    output logic         fmul_ce,
    input  logic [W-1:0] fmul_r,
    output logic [W-1:0] fadd_x,
    output logic [W-1:0] fadd_y,
    output logic         fadd_ce,
    input  logic [W-1:0] fadd_r,
    input  logic         state01,
    input  logic         state02,
    input  logic         state03,
    input  logic         state04,
    input  logic         state05,
    input  logic         state06,
    input  logic         state07,
    input  logic         state08,
    input  logic         state09,
    input  logic         state10,
    input  logic         state11,
    input  logic         state12,
    input  logic         state13,
    input  logic         state14,
    input  logic         state15
`ifdef FMAC_RESULT_REG_EN
    ,
    output logic [W-1:0] acc_r,
    output logic         acc_valid
`endif
);

    logic [15:1]  st_vec;
    logic [3:0]   step;
    logic [W-1:0] p1;

    assign st_vec = {state15, state14, state13, state12, state11, state10, state09, state08,
                     state07, state06, state05, state04, state03, state02, state01};
    assign step   = onehot_to_step(st_vec);

    // Hold P1 aside so the first add can pair it with P2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p1 <= '0;
        end else if (step == P1_CAPTURE) begin
            p1 <= fmul_r;
        end
    end

    fmac_operand_mux u_mux (
        .reset   (reset),
        .step    (step),
        .arg1    (arg1),
        .arg2    (arg2),
        .arg3    (arg3),
        .arg4    (arg4),
        .arg5    (arg5),
        .arg6    (arg6),
        .arg7    (arg7),
        .arg8    (arg8),
        .p1      (p1),
        .fmul_r  (fmul_r),
        .fadd_r  (fadd_r),
        .fmul_x  (fmul_x),
        .fmul_y  (fmul_y),
        .fmul_ce (fmul_ce),
        .fadd_x  (fadd_x),
        .fadd_y  (fadd_y),
        .fadd_ce (fadd_ce)
    );

`ifdef FMAC_RESULT_REG_EN
    logic [W-1:0] acc_q;
    logic         acc_valid_q;

    // Capture the finished sum once per run; a new run clears the valid flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else if (step == DONE) begin
            acc_q       <= fadd_r;
            acc_valid_q <= 1'b1;
        end else if (step == ISSUE_FIRST) begin
            acc_valid_q <= 1'b0;
        end
    end

    assign acc_r     = reset ? acc_q : '0;
    assign acc_valid = reset & acc_valid_q;
`endif

endmodule

// File: tb/tb_fmac_dot4_ctrl.sv
// Self-checking bench for fmac_dot4_ctrl. fmul/fadd are modelled as
// lookup tables of hand-computed FloPoCo results (unknown pairs give NaN).
module tb_fmac_dot4_ctrl;
    import fmac_pkg::*;

    localparam float_t F_M1  = 11'b01101110000; // -1
    localparam float_t F_1   = 11'b01001110000;
    localparam float_t F_2   = 11'b01010000000;
    localparam float_t F_3   = 11'b01010001000;
    localparam float_t F_4   = 11'b01010010000;
    localparam float_t F_5   = 11'b01010010100;
    localparam float_t F_6   = 11'b01010011000;
    localparam float_t F_7   = 11'b01010011100;
    localparam float_t F_8   = 11'b01010100000;
    localparam float_t F_M2  = 11'b01110000000; // -2
    localparam float_t F_10  = 11'b01010100100;
    localparam float_t F_12  = 11'b01010101000;
    localparam float_t F_14  = 11'b01010101100;
    localparam float_t F_30  = 11'b01010111110;
    localparam float_t F_40  = 11'b01011000100;
    localparam float_t F_44  = 11'b01011000110;
    localparam float_t F_56  = 11'b01011001100;
    localparam float_t F_96  = 11'b01011011000;
    localparam float_t F_100 = 11'b01011011001;
    localparam float_t F_Z   = 11'b00000000000;
    localparam float_t F_NAN = 11'b11000000000;

    typedef struct packed {
        int     cyc;
        logic   fmul_ce;
        logic   fadd_ce;
        float_t fmul_x;
        float_t fmul_y;
        float_t fadd_x;
        float_t fadd_y;
        float_t fadd_r;
`ifdef FMAC_RESULT_REG_EN
        logic   acc_valid;
        float_t acc_r;
`endif
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + external unit models ----------------
    float_t a [1:8];
    logic [15:1] st = '0;
    float_t fmul_x, fmul_y, fadd_x, fadd_y, fmul_r, fadd_r;
    logic   fmul_ce, fadd_ce;
`ifdef FMAC_RESULT_REG_EN
    float_t acc_r;
    logic   acc_valid;
`endif

    fmac_dot4_ctrl dut (
        .clk(clk), .reset(reset),
        .arg1(a[1]), .arg2(a[2]), .arg3(a[3]), .arg4(a[4]),
        .arg5(a[5]), .arg6(a[6]), .arg7(a[7]), .arg8(a[8]),
        .fmul_x(fmul_x), .fmul_y(fmul_y), .fmul_ce(fmul_ce), .fmul_r(fmul_r),
        .fadd_x(fadd_x), .fadd_y(fadd_y), .fadd_ce(fadd_ce), .fadd_r(fadd_r),
        .state01(st[1]), .state02(st[2]), .state03(st[3]), .state04(st[4]),
        .state05(st[5]), .state06(st[6]), .state07(st[7]), .state08(st[8]),
        .state09(st[9]), .state10(st[10]), .state11(st[11]), .state12(st[12]),
        .state13(st[13]), .state14(st[14]), .state15(st[15])
`ifdef FMAC_RESULT_REG_EN
        , .acc_r(acc_r), .acc_valid(acc_valid)
`endif
    );

    function automatic float_t mul_lut(input float_t x, input float_t y);
        case ({x, y})
            {F_1, F_2}:  return F_2;
            {F_M1, F_2}: return F_M2;
            {F_3, F_4}:  return F_12;
            {F_5, F_6}:  return F_30;
            {F_7, F_8}:  return F_56;
            {F_Z, F_Z}:  return F_Z;
            default:     return F_NAN;
        endcase
    endfunction

    function automatic float_t add_lut(input float_t x, input float_t y);
        case ({x, y})
            {F_2, F_12}:  return F_14;
            {F_14, F_30}: return F_44;
            {F_44, F_56}: return F_100;
            {F_M2, F_12}: return F_10;
            {F_10, F_30}: return F_40;
            {F_40, F_56}: return F_96;
            {F_Z, F_Z}:   return F_Z;
            default:      return F_NAN;
        endcase
    endfunction

    float_t m1 = '0, m2 = '0, ar = '0;
    always @(posedge clk) begin
        if (fmul_ce) begin
            m1 <= mul_lut(fmul_x, fmul_y);
            m2 <= m1;
        end
        if (fadd_ce) ar <= add_lut(fadd_x, fadd_y);
    end
    assign fmul_r = m2;
    assign fadd_r = ar;

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    always @(negedge clk) begin
        exp_t e, act;
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            act = '0;
            act.cyc     = cyc;
            act.fmul_ce = fmul_ce;
            act.fadd_ce = fadd_ce;
            act.fmul_x  = fmul_x;
            act.fmul_y  = fmul_y;
            act.fadd_x  = fadd_x;
            act.fadd_y  = fadd_y;
            act.fadd_r  = fadd_r;
`ifdef FMAC_RESULT_REG_EN
            act.acc_valid = acc_valid;
            act.acc_r     = acc_r;
`endif
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL cyc%0d outputs: actual ce=%b/%b mul=%h,%h add=%h,%h r=%h required cyc%0d ce=%b/%b mul=%h,%h add=%h,%h r=%h",
                         act.cyc, act.fmul_ce, act.fadd_ce, act.fmul_x, act.fmul_y, act.fadd_x, act.fadd_y, act.fadd_r,
                         e.cyc, e.fmul_ce, e.fadd_ce, e.fmul_x, e.fmul_y, e.fadd_x, e.fadd_y, e.fadd_r);
`ifdef FMAC_RESULT_REG_EN
                $display("  acc actual valid=%b r=%h required valid=%b r=%h", act.acc_valid, act.acc_r, e.acc_valid, e.acc_r);
`endif
            end
        end
    end

    // ---------------- driver ----------------
    float_t prev_r = '0;
`ifdef FMAC_RESULT_REG_EN
    float_t prev_acc = '0;
    logic   prev_valid = 1'b0;
`endif

    task automatic drive(input logic rst, input logic [15:1] s, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst;
        st = s;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    function automatic exp_t idle_exp(input float_t r);
        exp_t e;
        e = '0;
        e.fadd_r = r;
`ifdef FMAC_RESULT_REG_EN
        e.acc_valid = prev_valid;
        e.acc_r     = prev_acc;
`endif
        return e;
    endfunction

    // One schedule run through states 01..last_c with expected products/sums.
    task automatic run_dot(input float_t p1v, p2v, p3v, p4v, s1, s2, s3, input int last_c);
        for (int c = 1; c <= last_c; c++) begin
            exp_t e;
            logic [15:1] s;
            e = '0;
            s = '0;
            s[c] = 1'b1;
            case (c)
                1: begin e.fmul_x = a[1]; e.fmul_y = a[2]; end
                2: begin e.fmul_x = a[3]; e.fmul_y = a[4]; end
                3: begin e.fmul_x = a[5]; e.fmul_y = a[6]; end
                4: begin e.fmul_x = a[7]; e.fmul_y = a[8]; e.fadd_x = p1v; e.fadd_y = p2v; end
                5: begin e.fadd_x = s1; e.fadd_y = p3v; end
                6: begin e.fadd_x = s2; e.fadd_y = p4v; end
                default: ;
            endcase
            e.fmul_ce = (c <= 5);
            e.fadd_ce = (c >= 4) && (c <= 6);
            e.fadd_r  = (c <= 4) ? prev_r : (c == 5) ? s1 : (c == 6) ? s2 : s3;
`ifdef FMAC_RESULT_REG_EN
            e.acc_valid = (c == 1) ? prev_valid : (c >= 8);
            e.acc_r     = (c >= 8) ? s3 : prev_acc;
`endif
            drive(1'b1, s, e);
        end
        if (last_c == 15) begin
            prev_r = s3;
`ifdef FMAC_RESULT_REG_EN
            prev_valid = 1'b1;
            prev_acc   = s3;
`endif
        end
    endtask

    task automatic set_nominal();
        a[1] = F_1; a[2] = F_2; a[3] = F_3; a[4] = F_4;
        a[5] = F_5; a[6] = F_6; a[7] = F_7; a[8] = F_8;
    endtask

    initial begin
        exp_t e;
        logic [15:1] s;
        set_nominal();

        // reset state
        e = '0;
        drive(1'b0, '0, e);
        drive(1'b0, '0, e);

        // nominal 1..8 -> 100
        run_dot(F_2, F_12, F_30, F_56, F_14, F_44, F_100, 15);

        // idle: no state asserted, result held
        for (int i = 0; i < 5; i++) drive(1'b1, '0, idle_exp(prev_r));

        // sign: arg1 = -1 -> 96
        a[1] = F_M1;
        run_dot(F_M2, F_12, F_30, F_56, F_10, F_40, F_96, 15);

        // zeros -> 0
        for (int i = 1; i <= 8; i++) a[i] = F_Z;
        run_dot(F_Z, F_Z, F_Z, F_Z, F_Z, F_Z, F_Z, 15);

        // reset asserted mid-run in state05
        set_nominal();
        run_dot(F_2, F_12, F_30, F_56, F_14, F_44, F_100, 4);
        e = '0;
        e.fadd_r = F_14;
        s = '0; s[5] = 1'b1;
        drive(1'b0, s, e);
        s = '0; s[6] = 1'b1;
        drive(1'b0, s, e);
        prev_r = F_14;
`ifdef FMAC_RESULT_REG_EN
        prev_valid = 1'b0;
        prev_acc   = F_Z;
`endif
        drive(1'b1, '0, idle_exp(prev_r));

        // illegal multi-hot: state01 wins over state03
        e = idle_exp(prev_r);
        e.fmul_ce = 1'b1;
        e.fmul_x  = a[1];
        e.fmul_y  = a[2];
        s = '0; s[1] = 1'b1; s[3] = 1'b1;
        drive(1'b1, s, e);
`ifdef FMAC_RESULT_REG_EN
        prev_valid = 1'b0;
`endif
        drive(1'b1, '0, idle_exp(prev_r));

        // clean restart after the abandoned run
        run_dot(F_2, F_12, F_30, F_56, F_14, F_44, F_100, 15);
        drive(1'b1, '0, idle_exp(prev_r));

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fmac_dot4_ctrl.md
Name: fmac_dot4_ctrl

Overview:
- Sequencing controller that computes the 4-term dot product R = a1*a2 + a3*a4 + a5*a6 + a7*a8 over 11-bit FloPoCo floats.
- Time-shares one external pipelined multiplier (fmul, latency 2) and one external adder (fadd, latency 1).
- Stepped by an externally generated one-hot 15-state FSM.
- The final sum is left held on the adder's output, fadd_r.

Parameters:
- WE, 4, exponent width (bias 7).
- WF, 4, fraction width.
- W, 2+1+WE+WF = 11, word width: exn[10:9] (00 zero, 01 normal, 10 inf, 11 NaN), sign[8], exp[7:4], frac[3:0].

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- arg1..arg8  in  W each  operands, stable for the whole run
- fmul_x, fmul_y  out  W  multiplier operands
- fmul_ce  out  1  multiplier pipeline enable
- fmul_r  in  W  multiplier result, valid 2 enabled edges after issue
- fadd_x, fadd_y  out  W  adder operands
- fadd_ce  out  1  adder enable
- fadd_r  in  W  adder result, valid 1 enabled edge after issue
- state01..state15  in  1 each  one-hot schedule step; stateNN is high during cycle NN

Behaviour:
- All outputs are combinational decodes of the state inputs plus one internal register, p1 (W bits).
- Issue schedule:
  - state01: fmul_x=arg1, fmul_y=arg2
  - state02: arg3/arg4
  - state03: arg5/arg6
  - state04: arg7/arg8
  - other states: fmul_x = fmul_y = 0
- fmul_ce=1 in state01..state05, 0 otherwise. With ce low, fmul_r holds its last product.
- Products on fmul_r: P1 in cycle 3, P2 in cycle 4, P3 in cycle 5, P4 in cycle 6.
- p1 loads fmul_r on the rising edge ending state03; it holds otherwise.
- Accumulation (fadd_ce=1 only in these three states):
  - state04: fadd_x=p1, fadd_y=fmul_r (P2)
  - state05: fadd_x=fadd_r (P1+P2), fadd_y=fmul_r (P3)
  - state06: fadd_x=fadd_r, fadd_y=fmul_r (P4)
- Outside state04..06: fadd_ce=0, fadd_x = fadd_y = 0.
- Final sum appears on fadd_r from cycle 7 and stays held through state15 and any later idle cycles.
- Reset low, sampled at a rising edge:
  - p1 is cleared to 0 on that edge.
  - While reset is low, all outputs are forced to 0, including both ce outputs.
  - If reset is asserted mid-run, the run is abandoned. A fresh state01 restarts it cleanly.
- No state asserted (all-zero FSM): both ce = 0, all operand outputs 0.
- More than one state input high is illegal. Priority is then the lowest-numbered state; no error flag.
- No arithmetic is done in this block. Exceptions (NaN/inf) propagate through fmul/fadd untouched.

Optional Feature:
- Macro: FMAC_RESULT_REG_EN.
- Defined: adds outputs acc_r (W) and acc_valid (1).
  - acc_r loads fadd_r on the edge ending state07 and holds until reset.
  - acc_valid is registered: it goes high on the edge ending state07 and stays high until state01 or reset.
- Undefined: these ports and their logic are absent; the result is read from fadd_r only.

Decomposition:
- Package fmac_pkg holds:
  - W, WE, WF
  - float_t typedef (W-bit logic)
  - exn encoding constants
  - schedule step constants: ISSUE_FIRST=1, ISSUE_LAST=4, P1_CAPTURE=3, ADD_FIRST=4, ADD_LAST=6, DONE=7
- One natural sub-module: fmac_operand_mux, the state-to-operand/ce decode.
- p1 and the optional result register stay in the top.

Test Plan:
- Nominal, args 1.0..8.0 (01001110000, 01010000000, 01010001000, 01010010000, 01010010100, 01010011000, 01010011100, 01010100000), one-hot states 01..15:
  - fmul_r 01010000000 (2), 01010101000 (12), 01010111110 (30), 01011001100 (56) in cycles 3..6
  - fadd_r 01010101100 (14), 01011000110 (44)
  - final fadd_r = 01011011001 (100) from cycle 7 through end of state15
- Sign: arg1 = -1.0 (01101110000), rest nominal -> final 01011011000 (96).
- Zeros: all args 00000000000 -> final fadd_r 00000000000.
- Reset mid-run: drive reset low during state05 -> fmul_ce = fadd_ce = 0 and outputs 0 while low. After release and a restart from state01 -> 01011011001.
- Idle: all state inputs low for 5 cycles -> fmul_ce = fadd_ce = 0 and fadd_r unchanged.
- FMAC_RESULT_REG_EN: nominal run -> acc_valid rises after state07, acc_r = 01011011001.
